sram_burst_master: RTL
======================

# sram_burst_master

Request-side engine that drives the SRAM digital interface (`sram_itf`, master modport) on behalf of the QRAcc controller. It accepts one burst command at a time: a base row, a length, and a direction. For write bursts it streams words from a valid/ready write port into consecutive rows. For read bursts it issues read requests and returns `rd_data_o` words through a small credit-guarded FIFO. It sits between the controller/activation path and the SRAM slave, and it is the requesting end of the `rq_valid_i/rq_ready_o/rd_valid_o` protocol.

## Interface
Parameters:
- numRows, 128, SRAM rows; power of two; address width AW = $clog2(numRows)
- numCols, 32, SRAM word width
- rdFifoDepth, 4, read-return FIFO depth; power of two, ≥2

Ports:
- clk  in  1  single clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  burst command valid
- cmd_ready_o  out  1  command accepted on valid&ready
- cmd_wr_i  in  1  1 = write burst, 0 = read burst
- cmd_addr_i  in  AW  base row
- cmd_len_i  in  AW+1  word count, 0..numRows
- wdata_valid_i / wdata_ready_o  in/out  1  write-data handshake
- wdata_i  in  numCols  write word
- rdata_valid_o / rdata_ready_i  out/in  1  read-data handshake
- rdata_o  out  numCols  read word (FIFO head)
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse at burst completion
- err_o  out  1  sticky: rd_valid_o from SRAM with no read outstanding
- sram  sram_itf.master  —  rq_wr_i, rq_valid_i, wr_data_i, addr_i driven; rq_ready_o, rd_valid_o, rd_data_o sampled

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready_o=1. On acceptance, latch wr/addr/len and clear issue and receive counters.
  - len=0 → stay IDLE, pulse done_o next cycle, no SRAM traffic.
  - wr=1 → WRITE; wr=0 → READ.
- WRITE: rq_valid_i=wdata_valid_i, rq_wr_i=1, wr_data_i=wdata_i, wdata_ready_o=rq_ready_o (combinational pass-through). Each handshake increments issue count. When the last handshake occurs (issue count = len) → IDLE with done_o.
- READ: rq_valid_i=1, rq_wr_i=0 while issue<len and credit is available. Credit rule: outstanding + fifo_count + (rq_valid_i&rq_ready_o) ≤ rdFifoDepth. Once issue=len → DRAIN.
- DRAIN: wait until receive count = len → IDLE with done_o.
- addr_i = base + issue count, modulo numRows (wraps 127→0 at the default).
- rd_valid_o pushes rd_data_o into the FIFO and increments receive count. The FIFO can never overflow by construction.
- The FIFO drains independently of the FSM. A new command may be accepted while it still holds data.
- A rd_valid_o arriving when outstanding=0 sets err_o; that word is dropped. err_o clears only on reset.
- wdata_ready_o=0 and rq_valid_i=0 outside WRITE/READ respectively.

## Timing
- Reset values: cmd_ready_o=1, busy_o=0, done_o=0, err_o=0, rdata_valid_o=0, rq_valid_i=0, rq_wr_i=0, addr_i=0, wr_data_i=0, FIFO empty, state IDLE.
- The first SRAM request is presented the cycle after command acceptance.
- Sustains 1 request/cycle when rq_ready_o=1 (and, for reads, credit is available).
- done_o is asserted the cycle after the final write handshake or the final read-return capture. cmd_ready_o=1 in that same cycle.
- Read data appears on rdata_valid_o the cycle after its rd_valid_o capture.
- Simultaneous FIFO push and pop at full or empty is legal, and the count stays consistent.
- nrst asserted mid-burst: everything returns to reset values immediately. In-flight SRAM returns after reset are flagged by err_o.

## Configuration
- SRAM_BURST_STATS_EN defined: adds outputs stall_cycles_o[31:0] and words_o[31:0].
  - stall_cycles_o counts cycles with rq_valid_i&!rq_ready_o.
  - words_o counts completed word transfers.
  - Both are saturating and reset by nrst.
- Macro undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- qracc_pkg gains typedef enum logic [1:0] sram_burst_state_t {SB_IDLE, SB_WRITE, SB_READ, SB_DRAIN}.
- One sub-module, sram_burst_rd_fifo: synchronous FIFO, parameterised width/depth, exposes count.

## Test plan
- Write len=4 at addr 10, rq_ready_o always 1 → addr_i 10,11,12,13 on consecutive cycles, done_o one cycle after the 4th handshake.
- Read len=4 at addr 126 (numRows=128) → addr_i 126,127,0,1; data returned in order on rdata_o.
- Read len=8, rdata_ready_i=0, SRAM latency 1 → exactly 4 requests issued, then stall. Asserting rdata_ready_i resumes issue, and all 8 words are delivered.
- Command with len=0 → no rq_valid_i, done_o next cycle, cmd_ready_o stays 1.
- rq_ready_o toggling 1-0-1 during a 3-word write → wdata_ready_o mirrors it, exactly 3 SRAM writes occur.
- Reset asserted mid-read, then a spurious rd_valid_o → all outputs at reset values, then err_o=1 and held.

Source files
------------

// File: rtl/qracc_pkg.sv
// rtl/qracc_pkg.sv - shared types and helpers for the QRAcc SRAM request path
package qracc_pkg;

  typedef enum logic [1:0] {SB_IDLE, SB_WRITE, SB_READ, SB_DRAIN} sram_burst_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sram_itf.sv
// rtl/sram_itf.sv - SRAM digital interface; signal suffixes are from the slave's point of view
interface sram_itf #(
  parameter int numRows = 128,
  parameter int numCols = 32
) ();
  localparam int AW = $clog2(numRows);

  logic               rq_wr_i;
  logic               rq_valid_i;
  logic [numCols-1:0] wr_data_i;
  logic [AW-1:0]      addr_i;
  logic               rq_ready_o;
  logic               rd_valid_o;
  logic [numCols-1:0] rd_data_o;

  modport master (
    output rq_wr_i, rq_valid_i, wr_data_i, addr_i,
    input  rq_ready_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  rq_wr_i, rq_valid_i, wr_data_i, addr_i,
    output rq_ready_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/sram_burst_rd_fifo.sv
// rtl/sram_burst_rd_fifo.sv - read-return FIFO; the producer guarantees it never pushes when full
module sram_burst_rd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     s_tvalid_i,
  input  logic [WIDTH-1:0]         s_tdata_i,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic [WIDTH-1:0]         m_tdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign push       = s_tvalid_i;
  assign pop        = m_tvalid_o & m_tready_i;
  assign m_tvalid_o = (count_q != '0);
  assign m_tdata_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/sram_burst_master.sv
// rtl/sram_burst_master.sv - burst request engine for the SRAM interface
// Optional stall/word statistics outputs are built when SRAM_BURST_STATS_EN is defined.
module sram_burst_master
  import qracc_pkg::*;
#(
  parameter int numRows     = 128,
  parameter int numCols     = 32,
  parameter int rdFifoDepth = 4,
  localparam int AW         = $clog2(numRows)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_wr_i,
  input  logic [AW-1:0]      cmd_addr_i,
  input  logic [AW:0]        cmd_len_i,
  input  logic               wdata_valid_i,
  output logic               wdata_ready_o,
  input  logic [numCols-1:0] wdata_i,
  output logic               rdata_valid_o,
  input  logic               rdata_ready_i,
  output logic [numCols-1:0] rdata_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
`ifdef SRAM_BURST_STATS_EN
  output logic [31:0]        stall_cycles_o,
  output logic [31:0]        words_o,
`endif
  sram_itf.master            sram
);
  localparam int CW = $clog2(rdFifoDepth) + 1;

  sram_burst_state_t state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d, issue_q, issue_d, recv_q, recv_d;
  logic [CW-1:0] out_q, out_d, fifo_count;
  logic          done_q, done_d, err_q, err_d;
  logic          rq_hs, rd_push, spurious, credit_ok;

  assign cmd_ready_o = (state_q == SB_IDLE);
  assign busy_o      = (state_q != SB_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign sram.addr_i = base_q + issue_q[AW-1:0];

  // Requests in flight plus words parked in the FIFO may never exceed its depth.
  assign credit_ok = ({1'b0, out_q} + {1'b0, fifo_count}) < (CW+1)'(rdFifoDepth);
  assign rq_hs     = sram.rq_valid_i & sram.rq_ready_o;
  assign spurious  = sram.rd_valid_o & (out_q == '0);
  assign rd_push   = sram.rd_valid_o & ~spurious;

  always_comb begin
    sram.rq_valid_i = 1'b0;
    sram.rq_wr_i    = 1'b0;
    sram.wr_data_i  = '0;
    wdata_ready_o   = 1'b0;
    case (state_q)
      SB_WRITE: begin
        sram.rq_valid_i = wdata_valid_i;
        sram.rq_wr_i    = 1'b1;
        sram.wr_data_i  = wdata_i;
        wdata_ready_o   = sram.rq_ready_o;
      end
      SB_READ:  sram.rq_valid_i = credit_ok;
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    issue_d = rq_hs ? issue_q + (AW+1)'(1) : issue_q;
    recv_d  = rd_push ? recv_q + (AW+1)'(1) : recv_q;
    out_d   = out_q + CW'(rq_hs & ~sram.rq_wr_i) - CW'(rd_push);
    err_d   = err_q | spurious;
    done_d  = 1'b0;
    case (state_q)
      SB_IDLE: begin
        if (cmd_valid_i) begin
          base_d  = cmd_addr_i;
          len_d   = cmd_len_i;
          issue_d = '0;
          recv_d  = '0;
          if (cmd_len_i == '0) done_d = 1'b1;
          else if (cmd_wr_i)   state_d = SB_WRITE;
          else                 state_d = SB_READ;
        end
      end
      SB_WRITE: begin
        if (rq_hs && issue_d == len_q) begin
          state_d = SB_IDLE;
          done_d  = 1'b1;
        end
      end
      SB_READ: begin
        if (issue_d == len_q) begin
          if (recv_d == len_q) begin
            state_d = SB_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SB_DRAIN;
          end
        end
      end
      SB_DRAIN: begin
        if (recv_d == len_q) begin
          state_d = SB_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= SB_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      issue_q <= '0;
      recv_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  sram_burst_rd_fifo #(
    .WIDTH (numCols),
    .DEPTH (rdFifoDepth)
  ) u_rd_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .s_tvalid_i (rd_push),
    .s_tdata_i  (sram.rd_data_o),
    .m_tvalid_o (rdata_valid_o),
    .m_tready_i (rdata_ready_i),
    .m_tdata_o  (rdata_o),
    .count_o    (fifo_count)
  );

`ifdef SRAM_BURST_STATS_EN
  logic [31:0] stall_q, words_q;

  assign stall_cycles_o = stall_q;
  assign words_o        = words_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_q <= '0;
      words_q <= '0;
    end else begin
      if (sram.rq_valid_i && !sram.rq_ready_o) stall_q <= sat_inc32(stall_q);
      if ((rq_hs && sram.rq_wr_i) || rd_push)  words_q <= sat_inc32(words_q);
    end
  end
`endif
endmodule
